// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard and sequencing controller for the five-stage core. Each cycle
// it decides whether the PC and the F/D, D/E, E/M, M/W pipeline registers
// update, hold or flush. It resolves data-memory wait states, taken-branch
// redirects and load-use hazards, in that priority order.
//
// Optional feature macro: HAZARD_PERF_CNT_EN
//   defined   -> stall_cycles / flush_count performance counters are present
//   undefined -> those ports and counters are absent
//
// Ports:
//   clk              core clock, all state updates on its rising edge
//   reset            synchronous, active-low
//   id_rs1/id_rs2    source registers of the ID instruction
//   id_uses_rs1/2    ID instruction actually reads rs1 / rs2
//   ex_rd            destination register of the EX instruction
//   ex_mem_read      EX instruction is a load
//   ex_branch_taken  EX instruction redirects the PC
//   mem_req          MEM instruction accesses data memory
//   mem_ready        data memory completes the access this cycle
//   pc_hold          1 = PC keeps its value
//   fd/de/em_write   1 = stage register holds
//   fd/de/mw_flush   1 = stage register loads a bubble
//   mem_timeout      sticky error flag, cleared only by reset
//   dbg_state        current FSM state (0 = RUN, 1 = MEM_WAIT)
//   stall_cycles     cycles with pc_hold = 1 outside reset   (macro only)
//   flush_count      taken-branch flushes                    (macro only)
//
// Handshake: the memory side is a plain valid/ready pair. An access is
// outstanding while mem_req = 1 and mem_ready = 0; it completes in the cycle
// both are 1. mem_req must stay asserted until that cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module hazard_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int PERF_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_hold,
  output logic                  fd_write,
  output logic                  de_write,
  output logic                  em_write,
  output logic                  fd_flush,
  output logic                  de_flush,
  output logic                  mw_flush,
  output logic                  mem_timeout,
  output logic                  dbg_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]     stall_cycles,
  output logic [PERF_W-1:0]     flush_count
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  if (MEM_TIMEOUT < 1 || PERF_W < 1) begin : g_bad_param
    $error("hazard_ctrl: MEM_TIMEOUT and PERF_W must be at least 1");
  end

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_timeout;

  logic             w_wait;
  logic             w_load_use;
  logic             w_branch_flush;
  logic [CNT_W-1:0] w_cnt_inc;

  // ---------------------------------------------------------------------------
  // Hazard conditions
  // ---------------------------------------------------------------------------
  assign w_wait = mem_req && !mem_ready;

  // x0 is hard-wired zero, so a load targeting it can never create a hazard.
  assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

  assign w_branch_flush = reset && !w_wait && ex_branch_taken;

  // Saturating increment of the timeout counter.
  assign w_cnt_inc = (r_cnt == CNT_W'(MEM_TIMEOUT)) ? r_cnt : r_cnt + 1'b1;

  // ---------------------------------------------------------------------------
  // Pipeline control outputs: purely combinational, priority
  // reset > wait > branch > load-use > normal. The outputs do not depend on
  // the FSM state: a branch or load-use seen during MEM_WAIT stays frozen in
  // the held stages and is serviced naturally on the exit cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_hold  = 1'b0;
    fd_write = 1'b0;
    de_write = 1'b0;
    em_write = 1'b0;
    fd_flush = 1'b0;
    de_flush = 1'b0;
    mw_flush = 1'b0;
    if (!reset) begin
      pc_hold  = 1'b1;
      fd_flush = 1'b1;
      de_flush = 1'b1;
      mw_flush = 1'b1;
    end else if (w_wait) begin
      // Freeze everything up to MEM, drain a bubble into WB.
      pc_hold  = 1'b1;
      fd_write = 1'b1;
      de_write = 1'b1;
      em_write = 1'b1;
      mw_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // Squash the two wrong-path instructions in F/D and D/E.
      fd_flush = 1'b1;
      de_flush = 1'b1;
    end else if (w_load_use) begin
      // Hold PC and F/D for one cycle and send a bubble into EX.
      pc_hold  = 1'b1;
      fd_write = 1'b1;
      de_flush = 1'b1;
    end
  end

  assign mem_timeout = reset && r_mem_timeout;
  assign dbg_state   = (r_state == ST_MEM_WAIT);

  // ---------------------------------------------------------------------------
  // FSM with timeout counter. The counter counts cycles spent in MEM_WAIT and
  // saturates at MEM_TIMEOUT; the FSM keeps waiting after a timeout.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= ST_RUN;
      r_cnt         <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_wait) begin
            r_state <= ST_MEM_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_MEM_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == CNT_W'(MEM_TIMEOUT)) begin
            r_mem_timeout <= 1'b1;
          end
          if (!w_wait) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters, wrapping modulo 2^PERF_W.
  // ---------------------------------------------------------------------------
  logic [PERF_W-1:0] r_stall_cycles;
  logic [PERF_W-1:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (pc_hold) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if (w_branch_flush) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign stall_cycles = reset ? r_stall_cycles : '0;
  assign flush_count  = reset ? r_flush_count  : '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Self-checking bench for hazard_ctrl (MEM_TIMEOUT = 4). Each cycle the stimulus
// task drives inputs on the falling edge, pushes the expected output vector
// computed by a small behavioural model onto exp_q, samples the DUT mid-cycle
// and pops/compares. Directed sequences follow the hazard scenarios, then a
// constrained-random phase exercises mixed traffic and random resets.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_hazard_ctrl;

  localparam int MT = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
  logic       mem_req, mem_ready;
  logic       pc_hold, fd_write, de_write, em_write;
  logic       fd_flush, de_flush, mw_flush, mem_timeout, dbg_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_ctrl #(
    .REG_ADDR_W (5),
    .MEM_TIMEOUT(MT),
    .PERF_W     (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_hold        (pc_hold),
    .fd_write       (fd_write),
    .de_write       (de_write),
    .em_write       (em_write),
    .fd_flush       (fd_flush),
    .de_flush       (de_flush),
    .mw_flush       (mw_flush),
    .mem_timeout    (mem_timeout),
    .dbg_state      (dbg_state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count)
`endif
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_assert = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus record and behavioural model
  // Output vector bit order:
  //   [8] dbg_state [7] pc_hold [6] fd_write [5] de_write [4] em_write
  //   [3] fd_flush  [2] de_flush [1] mw_flush [0] mem_timeout
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       req;
    logic       rdy;
  } stim_t;

  logic [8:0] exp_q[$];
  logic [8:0] last_obs;
  int         cyc = 0;

  logic        m_st;
  int          m_cnt;
  logic        m_to;
  logic [31:0] m_stall;
  logic [31:0] m_flush;

  function automatic stim_t idle_stim();
    stim_t s;
    s     = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  function automatic logic [8:0] model_out(input stim_t s);
    logic       w, lu;
    logic [7:0] o;
    w  = s.req && !s.rdy;
    lu = s.mr && (s.rd != 5'd0) &&
         ((s.u1 && (s.rs1 == s.rd)) || (s.u2 && (s.rs2 == s.rd)));
    if (!s.rst)     o = 8'b1000_1110;
    else if (w)     o = 8'b1111_0010;
    else if (s.br)  o = 8'b0000_1100;
    else if (lu)    o = 8'b1100_0100;
    else            o = 8'b0000_0000;
    o[0] = s.rst && m_to;
    return {m_st, o};
  endfunction

  task automatic model_update(input stim_t s, input logic [8:0] e);
    logic w;
    w = s.req && !s.rdy;
    if (!s.rst) begin
      m_st = 1'b0; m_cnt = 0; m_to = 1'b0; m_stall = '0; m_flush = '0;
    end else begin
      m_stall = m_stall + 32'(e[7]);
      m_flush = m_flush + 32'(!w && s.br);
      if (!m_st) begin
        if (w) begin
          m_st  = 1'b1;
          m_cnt = 0;
        end
      end else begin
        if (m_cnt < MT) m_cnt++;
        if (m_cnt == MT) m_to = 1'b1;
        if (!w) m_st = 1'b0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle of stimulus with scoreboard push / pop
  // ---------------------------------------------------------------------------
  task automatic step(input stim_t s);
    logic [8:0] e;
    logic [8:0] got;
    @(negedge clk);
    reset           = s.rst;
    id_rs1          = s.rs1;
    id_rs2          = s.rs2;
    id_uses_rs1     = s.u1;
    id_uses_rs2     = s.u2;
    ex_rd           = s.rd;
    ex_mem_read     = s.mr;
    ex_branch_taken = s.br;
    mem_req         = s.req;
    mem_ready       = s.rdy;
    e = model_out(s);
    exp_q.push_back(e);
    #2;
    last_obs = {dbg_state, pc_hold, fd_write, de_write, em_write,
                fd_flush, de_flush, mw_flush, mem_timeout};
    got = exp_q.pop_front();
    check_eq($sformatf("outputs@%0d", cyc), {23'd0, last_obs}, {23'd0, got});
`ifdef HAZARD_PERF_CNT_EN
    check_eq($sformatf("stall_cycles@%0d", cyc), stall_cycles, s.rst ? m_stall : 32'd0);
    check_eq($sformatf("flush_count@%0d", cyc),  flush_count,  s.rst ? m_flush : 32'd0);
`endif
    @(posedge clk);
    model_update(s, e);
    cyc++;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : main
    stim_t s;
    m_st = 1'b0; m_cnt = 0; m_to = 1'b0; m_stall = '0; m_flush = '0;
    s = idle_stim();
    s.rst = 1'b0;
    reset = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = '0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state.
    step(s);
    check_eq("reset_outputs", {23'd0, last_obs[7:0]}, 32'h8E);
    step(idle_stim());
    check_eq("idle_after_reset", {23'd0, last_obs}, 32'h0);

    // Load-use via rs2, then the load moves on.
    s = idle_stim(); s.mr = 1'b1; s.rd = 5'd5; s.rs2 = 5'd5; s.u2 = 1'b1;
    step(s);
    check_eq("load_use_stall", {23'd0, last_obs}, 32'h0C4);
    step(idle_stim());
    // Load into x0 never stalls.
    s = idle_stim(); s.mr = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0; s.u1 = 1'b1;
    step(s);
    check_eq("load_use_x0", {23'd0, last_obs}, 32'h0);
    // Matching rs1 that is not used does not stall; rs1 used does.
    s = idle_stim(); s.mr = 1'b1; s.rd = 5'd7; s.rs1 = 5'd7; s.u1 = 1'b0;
    step(s);
    s.u1 = 1'b1;
    step(s);

    // Taken branch for one cycle.
    s = idle_stim(); s.br = 1'b1;
    step(s);
    check_eq("branch_flush", {23'd0, last_obs}, 32'h00C);
    step(idle_stim());

    // Memory wait of 3 cycles, then ready.
    s = idle_stim(); s.req = 1'b1;
    repeat (3) step(s);
    s.rdy = 1'b1;
    step(s);
    check_eq("mem_ready_normal", {23'd0, last_obs[7:0]}, 32'h0);
    step(idle_stim());
    check_eq("back_in_run", {31'd0, last_obs[8]}, 32'd0);

    // Simultaneous wait + branch + load-use.
    s = idle_stim(); s.req = 1'b1; s.br = 1'b1;
    s.mr = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3; s.u1 = 1'b1;
    repeat (2) step(s);
    s.rdy = 1'b1;
    step(s);
    check_eq("exit_branch_only", {23'd0, last_obs[7:0]}, 32'h0C);
    step(idle_stim());

    // Timeout: 10 wait cycles. Cycle 1 is in RUN, cycles 2..5 are the first
    // four cycles spent in MEM_WAIT, so the flag is visible from cycle 6.
    s = idle_stim(); s.req = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(s);
      if (i == 5) check_eq("timeout_not_yet", {31'd0, last_obs[0]}, 32'd0);
      if (i == 6) check_eq("timeout_raised",  {31'd0, last_obs[0]}, 32'd1);
    end
    s.rdy = 1'b1;
    step(s);
    repeat (2) step(idle_stim());
    check_eq("timeout_sticky", {31'd0, last_obs[0]}, 32'd1);
    s = idle_stim(); s.rst = 1'b0;
    step(s);
    step(idle_stim());
    check_eq("timeout_cleared", {23'd0, last_obs}, 32'h0);

    // Reset in the 2nd MEM_WAIT cycle.
    s = idle_stim(); s.req = 1'b1;
    repeat (2) step(s);
    s.rst = 1'b0;
    step(s);
    check_eq("reset_mid_wait", {23'd0, last_obs[7:0]}, 32'h8E);
    step(idle_stim());
    check_eq("after_reset_release", {23'd0, last_obs}, 32'h0);

    // Constrained-random traffic.
    for (int i = 0; i < 400; i++) begin
      s.rst = ($urandom_range(0, 39) != 0);
      s.rs1 = 5'($urandom_range(0, 3));
      s.rs2 = 5'($urandom_range(0, 3));
      s.rd  = 5'($urandom_range(0, 3));
      s.u1  = 1'($urandom_range(0, 1));
      s.u2  = 1'($urandom_range(0, 1));
      s.mr  = 1'($urandom_range(0, 1));
      s.br  = ($urandom_range(0, 3) == 0);
      s.req = 1'($urandom_range(0, 1));
      s.rdy = ($urandom_range(0, 9) < 4);
      step(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the five-stage core. Decides each cycle whether the PC and the four pipeline registers (F/D, D/E, E/M, M/W) update, hold or flush. It resolves load-use hazards, taken-branch redirects and data-memory wait states. It drives the `write` (1 = hold) and `flush` inputs of every pipeline register, plus the PC hold.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- MEM_TIMEOUT, 255, maximum MEM_WAIT cycles before `mem_timeout` is raised; must be at least 1
- PERF_W, 32, width of the performance counters

Ports:
- clk  in  1  core clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction reads rs1 / rs2
- ex_rd  in  REG_ADDR_W  destination register of the instruction in EX
- ex_mem_read  in  1  the EX instruction is a load
- ex_branch_taken  in  1  the EX instruction redirects the PC (taken branch or jump)
- mem_req  in  1  the MEM instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_hold  out  1  1 = PC keeps its value
- fd_write, de_write, em_write  out  1  1 = the stage register holds
- fd_flush, de_flush, mw_flush  out  1  1 = the stage register loads zero (bubble)
- mem_timeout  out  1  sticky error flag; cleared only by reset
- stall_cycles, flush_count  out  PERF_W  performance counters; present only under the configuration macro

## Operation
- Each output is a combinational function of the current inputs and the registered state. No output is registered.
- States:
  - RUN: normal issue.
  - MEM_WAIT: a memory access is outstanding.
- The wait condition is `mem_req && !mem_ready`.
- The load-use condition is all of the following:
  - `ex_mem_read` is 1 and `ex_rd` is not 0;
  - and either `id_uses_rs1` is set with `id_rs1 == ex_rd`, or `id_uses_rs2` is set with `id_rs2 == ex_rd`.
- Priority per cycle: wait first, then branch, then load-use, then normal.
  - Wait, in either state: `pc_hold`, `fd_write`, `de_write` and `em_write` are 1; `mw_flush` is 1; all other outputs are 0.
    - From RUN the next state is MEM_WAIT.
    - In MEM_WAIT the state remains MEM_WAIT.
  - Branch (no wait, `ex_branch_taken`): `fd_flush` and `de_flush` are 1; `pc_hold` is 0 so the PC loads the target.
  - Load-use (no wait, no branch): `pc_hold` and `fd_write` are 1; `de_flush` is 1, inserting one bubble.
  - Normal: all outputs are 0.
- MEM_WAIT → RUN on the first cycle with `mem_ready` = 1. That cycle is not a wait cycle, so branch, load-use or normal outputs apply in it.
- A branch or load-use condition present during MEM_WAIT is frozen in the held stages. It is therefore serviced on the exit cycle; no separate pending register is needed.
- Timeout counter:
  - Cleared on entry to MEM_WAIT; increments each cycle spent in MEM_WAIT.
  - When it reaches MEM_TIMEOUT, `mem_timeout` is set.
  - The counter saturates; the FSM keeps waiting.

## Timing
- Zero-cycle decision latency: the outputs in cycle N reflect the inputs of cycle N.
- The state, the timeout counter and `mem_timeout` update at the clk rising edge.
- While `reset` = 0:
  - state becomes RUN; the timeout counter becomes 0; `mem_timeout` becomes 0; performance counters become 0.
  - Outputs are forced to `pc_hold` = 1 and `fd_flush` = `de_flush` = `mw_flush` = 1; all holds and other outputs are 0.
- Reset asserted mid-MEM_WAIT: the FSM returns to RUN on that edge; the outstanding access is abandoned.
- A taken branch costs 2 bubbles. A load-use costs 1 stall cycle. A memory wait of k cycles costs k stall cycles.
- Load-use with `ex_rd` = 0 never stalls.

## Configuration
- HAZARD_PERF_CNT_EN, defined:
  - `stall_cycles` increments on every cycle with `pc_hold` = 1 outside reset.
  - `flush_count` increments on every branch flush.
  - Both wrap modulo 2^PERF_W.
- HAZARD_PERF_CNT_EN, undefined: both ports and their counters are absent; all other behaviour is identical.

## Test plan
- Load-use: `ex_mem_read` = 1, `ex_rd` = 5, `id_rs2` = 5, `id_uses_rs2` = 1 → one cycle of `pc_hold` = `fd_write` = `de_flush` = 1, then normal once the load moves to MEM.
- Taken branch: `ex_branch_taken` for 1 cycle → `fd_flush` = `de_flush` = 1 and `pc_hold` = 0 in that cycle only; `flush_count` increments by 1.
- Memory wait: `mem_req` = 1 with `mem_ready` low for 3 cycles → 3 cycles of holds plus `mw_flush`; normal outputs on the `mem_ready` cycle; state back in RUN.
- Simultaneous wait, branch and load-use → wait outputs only; on `mem_ready` the branch flush applies and the load-use stall does not.
- Timeout: MEM_TIMEOUT = 4, `mem_ready` held low for 10 cycles → `mem_timeout` rises after the 4th wait cycle and stays set until `reset` = 0.
- Reset mid-wait: drive `reset` low in the 2nd MEM_WAIT cycle → state RUN, counters 0, reset output values as listed in Timing; after release with no hazards, all outputs 0.
